// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_outValid;

  logic             w_accept;
  logic             w_handoff;
  logic             w_running;
  logic             w_lastBit;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_brNext;

`ifdef SERIAL_SUB_OVF_EN
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_ovf;
`endif

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_handoff = r_outValid && out_ready;
  assign w_running = (r_state == RUN);
  assign w_lastBit = w_running && (r_cnt == LAST_BIT);

  // One full-subtractor cell fed by the low bits of the operand shifters.
  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_brNext = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (in_valid)  w_stateNext = RUN;
      RUN:  if (w_lastBit) w_stateNext = DONE;
      DONE: if (out_ready) w_stateNext = IDLE;
      default:             w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_cnt <= '0;
      end else if (w_running) begin
        r_a    <= r_a >> 1;
        r_b    <= r_b >> 1;
        r_br   <= w_brNext;
        r_diff <= {w_d, r_diff[WIDTH-1:1]};
        r_cnt  <= r_cnt + CW'(1);
        if (w_lastBit) begin
          r_bout <= w_brNext;
        end
      end

      if (w_lastBit) begin
        r_outValid <= 1'b1;
      end else if (w_handoff) begin
        r_outValid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // The MSB of the result is the bit produced on the final cycle, so ovf uses w_d directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aMsb <= 1'b0;
      r_bMsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_aMsb <= a[WIDTH-1];
        r_bMsb <= b[WIDTH-1];
      end
      if (w_lastBit) begin
        r_ovf <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
      end
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule
